// File: rtl/_reg_arbiter.sv
// Round-robin arbiter/sequencer for one shared WIDTH-bit register.
// Grants one requester at a time, with capped locked bursts.
module _reg_arbiter #(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N-1:0]       lock,
  input  logic [N*WIDTH-1:0] wdata,
  input  logic               clr,
  output logic [N-1:0]       grant,
  output logic               wr_en,
  output logic [WIDTH-1:0]   q,
  output logic               busy
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, OWN} state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [3:0]       burst_q, burst_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic             found;
  logic [PW-1:0]    win;
  logic [PW-1:0]    idx;
  logic             write;
  logic             others;
  logic             stay;
  logic [4:0]       burst_inc;

  // Round-robin scan starting after ptr; ptr itself is checked last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Owner write and burst-hold qualification.
  always_comb begin
    write     = |(grant_q & req);
    others    = |(req & ~grant_q);
    burst_inc = {1'b0, burst_q} + 5'd1;
    stay      = write && lock[ptr_q] &&
                ((burst_inc < 5'(MAX_BURST)) || !others);
  end

  // Next-state: ownership, pointer, burst count and shared register.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = OWN;
          grant_d      = '0;
          grant_d[win] = 1'b1;
          ptr_d        = win;
          burst_d      = '0;
        end
      end
      OWN: begin
        if (stay) begin
          // Saturate so a long sole-owner burst cannot wrap
          // back under the cap.
          burst_d = (burst_q == 4'hF) ? burst_q : burst_inc[3:0];
        end else if (found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          ptr_d        = win;
          burst_d      = '0;
        end else begin
          state_d = IDLE;
          grant_d = '0;
          burst_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    if (clr) begin
      q_d = '0;
    end else if (write) begin
      q_d = wdata[int'(ptr_q)*WIDTH +: WIDTH];
    end else begin
      q_d = q_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PW'(N - 1);
      burst_q <= '0;
      grant_q <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      grant_q <= grant_d;
      q_q     <= q_d;
    end
  end

  assign grant = grant_q;
  assign wr_en = write;
  assign q     = q_q;
  assign busy  = (state_q == OWN);

endmodule

// File: tb/tb__reg_arbiter.sv
// Bench for _reg_arbiter: rule-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb__reg_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wdata;
  logic           clr;
  logic [N-1:0]   grant;
  logic           wr_en;
  logic [W-1:0]   q;
  logic           busy;

  int tests;
  int fails;

  _reg_arbiter #(.WIDTH(W), .N(N), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .lock  (lock),
    .wdata (wdata),
    .clr   (clr),
    .grant (grant),
    .wr_en (wr_en),
    .q     (q),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner index (-1 = none), last winner, writes so far.
  int       m_own;
  int       m_ptr;
  int       m_burst;
  logic [7:0] m_q;
  logic     started;

  initial begin
    started = 1'b0;
    m_own   = -1;
    m_ptr   = N - 1;
    m_burst = 0;
    m_q     = '0;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int w, own, ptr, bur, ii;
    logic [7:0] nq;
    logic wr, oth;
    own = m_own;
    ptr = m_ptr;
    bur = m_burst;
    if (reset) begin
      own = -1;
      ptr = N - 1;
      bur = 0;
      nq  = '0;
    end else begin
      w = -1;
      for (int k = 1; k <= N; k++) begin
        ii = (m_ptr + k) % N;
        if (w < 0 && req[ii]) w = ii;
      end
      wr = (own >= 0) ? req[own] : 1'b0;
      if (clr) nq = '0;
      else if (wr) nq = wdata[own*W +: W];
      else nq = m_q;
      oth = 1'b0;
      for (int i = 0; i < N; i++)
        if (i != own && req[i]) oth = 1'b1;
      if (own < 0) begin
        if (w >= 0) begin
          own = w; ptr = w; bur = 0;
        end
      end else if (wr && lock[own] && ((bur + 1 < MB) || !oth)) begin
        bur = bur + 1;
      end else if (w >= 0) begin
        own = w; ptr = w; bur = 0;
      end else begin
        own = -1; bur = 0;
      end
    end
    m_own   <= own;
    m_ptr   <= ptr;
    m_burst <= bur;
    m_q     <= nq;
    started <= 1'b1;
  end

  always @(negedge clk) begin
    int eg;
    int ew;
    if (started) begin
      eg = (m_own < 0) ? 0 : (1 << m_own);
      ew = (m_own < 0) ? 0 : int'(req[m_own]);
      chk("model_grant", int'(grant), eg);
      chk("model_busy", int'(busy), int'(m_own >= 0));
      chk("model_q", int'(q), int'(m_q));
      chk("model_wr_en", int'(wr_en), ew);
      chk("onehot", int'($countones(grant) <= 1), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input int i, input logic [7:0] v);
    wdata[i*W +: W] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    clr   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    req   = 4'b1111;
    lock  = '0;
    clr   = 1'b0;
    wdata = '0;
    setw(0, 8'h11); setw(1, 8'h22);
    setw(2, 8'h33); setw(3, 8'h44);

    // Reset held with all requesting, then round robin.
    tick(); tick();
    chk("rst_grant", int'(grant), 0);
    chk("rst_q", int'(q), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    tick();
    chk("first_grant", int'(grant), 4'b0001);
    chk("first_busy", int'(busy), 1);
    tick(); chk("rr_q0", int'(q), 8'h11); chk("rr_g1", int'(grant), 4'b0010);
    tick(); chk("rr_q1", int'(q), 8'h22); chk("rr_g2", int'(grant), 4'b0100);
    tick(); chk("rr_q2", int'(q), 8'h33); chk("rr_g3", int'(grant), 4'b1000);
    tick(); chk("rr_q3", int'(q), 8'h44); chk("rr_g0", int'(grant), 4'b0001);
    tick(); chk("rr_q4", int'(q), 8'h11);

    // Locked burst capped at MB writes, then hand over to 2.
    do_reset();
    setw(0, 8'hAA); setw(2, 8'hCC);
    req  = 4'b0101;
    lock = 4'b0001;
    tick(); chk("lk_g", int'(grant), 4'b0001);
    for (int i = 1; i < MB; i++) begin
      tick();
      chk("lk_q", int'(q), 8'hAA);
      chk("lk_hold", int'(grant), 4'b0001);
    end
    tick();
    chk("lk_qlast", int'(q), 8'hAA);
    chk("lk_move", int'(grant), 4'b0100);
    tick(); chk("lk_q2", int'(q), 8'hCC);

    // Sole locked requester is never forced off.
    do_reset();
    req  = 4'b0010;
    lock = 4'b0010;
    tick(); chk("sole_g", int'(grant), 4'b0010);
    for (int i = 0; i < 10; i++) begin
      setw(1, 8'(8'h50 + i));
      #1 chk("sole_wr", int'(wr_en), 1);
      tick();
      chk("sole_q", int'(q), 8'h50 + i);
      chk("sole_hold", int'(grant), 4'b0010);
    end

    // clr wins over a same-cycle write; rotation continues.
    do_reset();
    setw(0, 8'hA5); setw(1, 8'h22);
    req  = 4'b1111;
    lock = '0;
    tick(); chk("clr_g", int'(grant), 4'b0001);
    clr = 1'b1;
    #1 chk("clr_wr", int'(wr_en), 1);
    tick();
    chk("clr_q", int'(q), 0);
    chk("clr_g2", int'(grant), 4'b0010);
    clr = 1'b0;
    tick(); chk("clr_q2", int'(q), 8'h22);

    // Reset in the middle of a locked burst.
    reset = 1'b0;
    req   = 4'b0101;
    lock  = 4'b0001;
    do_reset();
    req  = 4'b0101;
    lock = 4'b0001;
    tick(); tick();
    chk("mid_q", int'(q), 8'hA5);
    reset = 1'b1;
    tick();
    chk("mid_g", int'(grant), 0);
    chk("mid_q0", int'(q), 0);
    chk("mid_b", int'(busy), 0);
    reset = 1'b0;

    // Owner drops req while holding a lock.
    do_reset();
    setw(0, 8'h0F); setw(1, 8'hF0);
    req  = 4'b0011;
    lock = 4'b0001;
    tick(); chk("drop_g0", int'(grant), 4'b0001);
    tick(); chk("drop_q0", int'(q), 8'h0F); chk("drop_hold", int'(grant), 4'b0001);
    req = 4'b0010;
    #1 chk("drop_wr", int'(wr_en), 0);
    tick();
    chk("drop_q", int'(q), 8'h0F);
    chk("drop_g1", int'(grant), 4'b0010);
    tick(); chk("drop_q1", int'(q), 8'hF0);

    req = '0;
    tick(); tick();
    chk("idle_g", int'(grant), 0);
    chk("idle_b", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/_reg_arbiter.md
# _reg_arbiter

- Round-robin arbiter and sequencer sharing one WIDTH-bit register among N requesters.
- Each cycle, at most one granted requester loads its data word into the shared register.
- A requester may hold ownership for a locked burst, capped at MAX_BURST writes so no requester starves.
- Sits in front of the flip-flop register datapath and is its only write path.

## Interface
Parameters:
- WIDTH, 8, width of the shared register and of each requester data word
- N, 4, number of requesters (2..8)
- MAX_BURST, 4, max consecutive locked writes by one owner while others wait (1..15)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset; one clock, no other clock domain
- req  input  N  req[i]: requester i wants to write
- lock  input  N  lock[i]: requester i wants to keep ownership after this write
- wdata  input  N*WIDTH  word i at wdata[i*WIDTH +: WIDTH]
- clr  input  1  synchronous clear of the shared register
- grant  output  N  registered one-hot (or zero) ownership vector
- wr_en  output  1  combinational, |(grant & req): a write occurs at the next edge
- q  output  WIDTH  shared register contents
- busy  output  1  registered, 1 when state is OWN

## Operation
- Registered state: state (IDLE/OWN), ptr (index of last winner), burst (write counter, 4 bits), grant, q.
- Round-robin pick: scan indices ptr+1, ptr+2, … modulo N; the first index with req=1 wins. The current owner is checked last.
- IDLE:
  - any req → state OWN, grant = onehot(winner), ptr = winner, burst = 0.
  - No write happens in IDLE.
- OWN with owner o:
  - req[o]=1: q ← wdata[o], burst ← burst+1.
  - Stay (grant unchanged) if req[o] && lock[o] && (burst+1 < MAX_BURST, or no other req).
  - Otherwise re-arbitrate excluding nothing:
    - a winner exists → grant moves to it, ptr = winner, burst = 0 (may be o again only if o is the sole requester).
    - none → IDLE, grant = 0.
  - req[o]=0: no write; re-arbitrate as above.
- clr=1: q ← 0 at the edge, overriding a write the same cycle. Arbitration, grant, ptr and burst behave as if clr=0.
- reset=1 (overrides everything, including mid-burst): state IDLE, grant 0, busy 0, q 0, ptr N-1 (requester 0 wins first), burst 0.
- wr_en=1 exactly on cycles whose following edge loads q (ignores clr).

## Timing
- req sampled at edge k → grant and busy high after edge k. Write at edge k+1; q valid after edge k+1. Request-to-data latency is 2 edges.
- Back-to-back handover: grant moves at the same edge as the owner's last write; no idle cycle between owners.
- Unlocked owner with continuous req and no competitor: re-granted every cycle, writing every cycle.
- Locked owner with a competitor: exactly MAX_BURST writes, then grant moves at the edge of the MAX_BURST-th write.
- req[i] dropped while granted: that cycle writes nothing and grant moves or clears at that edge.
- grant never has more than one bit set; q changes only on edges where wr_en or clr is 1.

## Test plan
- Reset: hold reset 2 cycles with all req=1, then release. Required: grant=0, q=0, busy=0 during reset. After release, grant=4'b0001 after 1 edge; q=wdata[0] after 2 edges.
- Round robin, unlocked: req=4'b1111, wdata = 8'h11/22/33/44. Required: grant sequence 0001→0010→0100→1000→0001; q sequence 11, 22, 33, 44, 11 on consecutive edges.
- Locked burst cap, MAX_BURST=4: req0 with lock0=1, and req2 both held high. Required: q=wdata[0] for exactly 4 writes, then grant=4'b0100 and the next write loads wdata[2].
- Sole locked requester: req1 and lock1 held for 10 cycles. Required: grant=0010 throughout; 10 writes; no forced release.
- clr collision: clr=1 on a cycle with wr_en=1 and wdata=8'hA5. Required: q=0 after the edge; grant rotation unchanged.
- Mid-burst reset and requester drop:
  - Reset during a locked burst → all outputs return to reset values next edge.
  - Owner drops req while granted → no write, and grant moves to the next requester at that edge.
